proc_fetch_inst_queue: RTL and testbench

Fetch-side instruction queue between the instruction-memory response port and the decode stage of the pipelined processor. It pairs each returning instruction word with the PC of the request that produced it, buffers up to `DEPTH` instructions, and presents them in order to decode, where the immediate generator and control decoder consume them. Credit-based flow control toward fetch guarantees every response has a slot. Squash support flushes buffered instructions and discards responses to wrong-path requests still in flight.

---
 rtl/proc_fetch_inst_queue.sv | 111 +++++++++++
 tb/tb_proc_fetch_inst_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_inst_queue.sv
// Fetch-side instruction queue: pairs imem responses with their request PCs,
// buffers them for decode and discards wrong-path responses after a squash.
module proc_fetch_inst_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_fire,
    input  logic [31:0] req_pc,
    output logic        req_rdy,
    input  logic        imemresp_val,
    output logic        imemresp_rdy,
    input  logic [31:0] imemresp_data,
    input  logic        squash,
    output logic        deq_val,
    input  logic        deq_rdy,
    output logic [31:0] deq_inst,
    output logic [31:0] deq_pc
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned XW = 32;

    logic [XW-1:0] pend_pc [DEPTH];
    logic [XW-1:0] q_pc    [DEPTH];
    logic [XW-1:0] q_inst  [DEPTH];

    logic [PW-1:0] pend_wr, pend_rd, q_wr, q_rd;
    logic [PW-1:0] pend_wr_n, pend_rd_n, q_wr_n, q_rd_n;
    logic [CW-1:0] count, inflight, drop;
    logic [CW-1:0] count_n, inflight_n, drop_n;
    logic          req_rdy_q, req_rdy_n;

    logic accept, drop_resp, enq, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign imemresp_rdy = reset;
    assign deq_val      = (count != '0);
    assign deq_pc       = q_pc[q_rd];
    assign deq_inst     = q_inst[q_rd];
    assign req_rdy      = req_rdy_q;

    assign accept    = imemresp_val && imemresp_rdy;
    assign drop_resp = accept && (drop != '0);
    assign enq       = accept && !drop_resp && !squash;
    assign deq       = deq_val && deq_rdy && !squash;

    // Next-state for counters and pointers; squash overrides queue activity.
    always_comb begin
        pend_wr_n  = pend_wr;
        pend_rd_n  = pend_rd;
        q_wr_n     = q_wr;
        q_rd_n     = q_rd;
        count_n    = count;
        drop_n     = drop;
        inflight_n = inflight + CW'(req_fire) - CW'(accept);

        if (req_fire) pend_wr_n = ptr_inc(pend_wr);
        if (accept)   pend_rd_n = ptr_inc(pend_rd);

        if (squash) begin
            q_wr_n  = '0;
            q_rd_n  = '0;
            count_n = '0;
            drop_n  = inflight - CW'(accept);
        end else begin
            if (enq) q_wr_n = ptr_inc(q_wr);
            if (deq) q_rd_n = ptr_inc(q_rd);
            count_n = count + CW'(enq) - CW'(deq);
            drop_n  = drop - CW'(drop_resp);
        end

        req_rdy_n = (SW'(inflight_n) + SW'(count_n)) < SW'(DEPTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_wr   <= '0;
            pend_rd   <= '0;
            q_wr      <= '0;
            q_rd      <= '0;
            count     <= '0;
            inflight  <= '0;
            drop      <= '0;
            req_rdy_q <= 1'b0;
        end else begin
            pend_wr   <= pend_wr_n;
            pend_rd   <= pend_rd_n;
            q_wr      <= q_wr_n;
            q_rd      <= q_rd_n;
            count     <= count_n;
            inflight  <= inflight_n;
            drop      <= drop_n;
            req_rdy_q <= req_rdy_n;
        end
    end

    // Payload storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (req_fire) pend_pc[pend_wr] <= req_pc;
        if (enq) begin
            q_pc[q_wr]   <= pend_pc[pend_rd];
            q_inst[q_wr] <= imemresp_data;
        end
    end

endmodule

// File: tb/tb_proc_fetch_inst_queue.sv
// Randomized and directed bench for proc_fetch_inst_queue at DEPTH 2 and 4,
// checked against a queue-based model of in-flight requests and buffered entries.
module tb_proc_fetch_inst_queue;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic        fire;
    logic [31:0] pc;
    logic        resp_val;
    logic [31:0] resp_data;
    logic        squash_s;
    logic        deq_rdy_s;

    logic        fire2, fire4, resp2, resp4, rst2, rst4;
    logic        rdy2, rdy4, irdy2, irdy4, val2, val4;
    logic [31:0] inst2, inst4, pc2, pc4;
    logic        cur_rdy, cur_irdy, cur_val;
    logic [31:0] cur_inst, cur_pc;

    assign fire2 = fire && !sel;
    assign fire4 = fire && sel;
    assign resp2 = resp_val && !sel;
    assign resp4 = resp_val && sel;
    assign rst2  = rstn && !sel;
    assign rst4  = rstn && sel;

    assign cur_rdy  = sel ? rdy4  : rdy2;
    assign cur_irdy = sel ? irdy4 : irdy2;
    assign cur_val  = sel ? val4  : val2;
    assign cur_inst = sel ? inst4 : inst2;
    assign cur_pc   = sel ? pc4   : pc2;

    proc_fetch_inst_queue #(.DEPTH(2)) u_dut2 (
        .clk(clk), .reset(rst2),
        .req_fire(fire2), .req_pc(pc), .req_rdy(rdy2),
        .imemresp_val(resp2), .imemresp_rdy(irdy2), .imemresp_data(resp_data),
        .squash(squash_s),
        .deq_val(val2), .deq_rdy(deq_rdy_s), .deq_inst(inst2), .deq_pc(pc2)
    );

    proc_fetch_inst_queue #(.DEPTH(4)) u_dut4 (
        .clk(clk), .reset(rst4),
        .req_fire(fire4), .req_pc(pc), .req_rdy(rdy4),
        .imemresp_val(resp4), .imemresp_rdy(irdy4), .imemresp_data(resp_data),
        .squash(squash_s),
        .deq_val(val4), .deq_rdy(deq_rdy_s), .deq_inst(inst4), .deq_pc(pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit drop; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    pend_t       pend[$];
    ent_t        instq[$];
    logic [31:0] got_pc[$];
    logic [31:0] next_pc;
    int          n_fired;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        int depth;
        depth = sel ? 4 : 2;
        return (pend.size() + instq.size()) < depth;
    endfunction

    // One clock: drive inputs, update the model at the edge, compare after it.
    task automatic cycle(input bit want_fire, input bit want_resp, input bit sq, input bit drdy);
        bit    f, r;
        pend_t p;
        f = want_fire && cur_rdy && model_rdy();
        r = want_resp && (pend.size() != 0);
        fire      = f;
        pc        = next_pc;
        resp_val  = r;
        resp_data = $urandom;
        squash_s  = sq;
        deq_rdy_s = drdy;
        if (cur_val && drdy && !sq) got_pc.push_back(cur_pc);
        @(posedge clk);
        if ((instq.size() != 0) && drdy && !sq) void'(instq.pop_front());
        if (r) begin
            assert (pend.size() != 0) else $error("imem response with nothing in flight");
            p = pend.pop_front();
            if (!p.drop && !sq) instq.push_back('{pc: p.pc, inst: resp_data});
        end
        if (sq) begin
            instq.delete();
            foreach (pend[i]) pend[i].drop = 1'b1;
        end
        if (f) begin
            pend.push_back('{pc: next_pc, drop: 1'b0});
            next_pc = next_pc + 32'd4;
            n_fired++;
        end
        @(negedge clk);
        fire     = 1'b0;
        resp_val = 1'b0;
        squash_s = 1'b0;
        check("deq_val", 32'(cur_val), 32'(instq.size() != 0));
        check("req_rdy", 32'(cur_rdy), 32'(model_rdy()));
        check("imemresp_rdy", 32'(cur_irdy), 32'd1);
        if (instq.size() != 0) begin
            check("deq_pc", cur_pc, instq[0].pc);
            check("deq_inst", cur_inst, instq[0].inst);
        end
    endtask

    task automatic do_reset(input bit s);
        @(negedge clk);
        rstn      = 1'b0;
        sel       = s;
        fire      = 1'b0;
        resp_val  = 1'b0;
        squash_s  = 1'b0;
        deq_rdy_s = 1'b0;
        pend.delete();
        instq.delete();
        got_pc.delete();
        n_fired   = 0;
        next_pc   = 32'h200;
        @(negedge clk);
        check("rst_deq_val", 32'(cur_val), 32'd0);
        check("rst_req_rdy", 32'(cur_rdy), 32'd0);
        check("rst_imemresp_rdy", 32'(cur_irdy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", 32'(cur_rdy), 32'd1);
    endtask

    task automatic check_order(input string tag, input int n);
        check({tag, "_count"}, 32'(got_pc.size()), 32'(n));
        for (int k = 0; k < n; k++)
            check(tag, (k < got_pc.size()) ? got_pc[k] : 32'hdead_beef, 32'h200 + 32'(4 * k));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sq;
        n_checks  = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        sel       = 1'b0;
        fire      = 1'b0;
        pc        = '0;
        resp_val  = 1'b0;
        resp_data = '0;
        squash_s  = 1'b0;
        deq_rdy_s = 1'b0;
        next_pc   = 32'h200;
        n_fired   = 0;

        // Streaming, DEPTH 2, decode always ready.
        do_reset(1'b0);
        for (int i = 0; i < 40 && got_pc.size() < 3; i++) cycle(n_fired < 3, 1'b1, 1'b0, 1'b1);
        check_order("stream_pc", 3);

        // Backpressure: two responses fill both credits.
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("bp_val", 32'(cur_val), 32'd1);
        check("bp_rdy", 32'(cur_rdy), 32'd0);
        check("bp_head", cur_pc, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_hold", cur_pc, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_credit", 32'(cur_rdy), 32'd1);
        check("bp_next_head", cur_pc, 32'h204);

        // Squash with one queued entry and one request in flight.
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("sq_val", 32'(cur_val), 32'd0);
        next_pc = 32'h300;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("sq_late_dropped", 32'(cur_val), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("sq_redirect_val", 32'(cur_val), 32'd1);
        check("sq_redirect_pc", cur_pc, 32'h300);

        // Squash coinciding with a response and a redirected request.
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        next_pc = 32'h400;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("sqc_val", 32'(cur_val), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("sqc_val2", 32'(cur_val), 32'd1);
        check("sqc_pc", cur_pc, 32'h400);

        // Wrap, DEPTH 4, random response timing and decode stalls.
        do_reset(1'b1);
        for (int i = 0; i < 400 && got_pc.size() < 10; i++)
            cycle(n_fired < 10, $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 2) != 0);
        check_order("wrap_pc", 10);

        // Random traffic with squashes on both depths.
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int i = 0; i < 400; i++) begin
                sq = ($urandom_range(0, 15) == 0);
                if (sq) next_pc = 32'h1000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, sq,
                      $urandom_range(0, 3) != 0);
            end
        end

        // Asynchronous reset pulsed between edges with two entries queued.
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("ar_pre_val", 32'(cur_val), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("ar_deq_val", 32'(cur_val), 32'd0);
        check("ar_req_rdy", 32'(cur_rdy), 32'd0);
        check("ar_imemresp_rdy", 32'(cur_irdy), 32'd0);
        #1 rstn = 1'b1;
        pend.delete();
        instq.delete();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("ar_post_val", 32'(cur_val), 32'd0);
        check("ar_post_rdy", 32'(cur_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
